aes_shiftrows_param: RTL and testbench

Parametrised, row-serial AES/Rijndael ShiftRows unit with a level-sensitive start/finish handshake. It supports forward and inverse mode, and Rijndael block widths of 4, 6 or 8 columns. An AddRoundKey XOR can be compiled in. It sits in the round datapath between SubBytes and MixColumns, and replaces the fixed 128-bit forward-only ShiftRows step.

---
 rtl/aes_shiftrows_param_pkg.sv | 13 +
 rtl/aes_shiftrows_param_row_rotate.sv | 16 +
 rtl/aes_shiftrows_param.sv | 82 ++++++++
 tb/tb_aes_shiftrows_param.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/aes_shiftrows_param_pkg.sv
// aes_pkg: shared types, NB legality check and row shift offsets for the parametrised ShiftRows unit
package aes_pkg;
  localparam int MAX_NB = 8;
  typedef logic [7:0] aes_byte_t;
  typedef aes_byte_t [MAX_NB-1:0] aes_row_t;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} aes_sr_state_e;
  function automatic bit nb_legal(input int nb);
    return nb == 4 || nb == 6 || nb == 8;
  endfunction
  function automatic logic [2:0] shift_offset(input int nb, input logic [1:0] row);
    return (nb == 8 && row > 2'd1) ? 3'(row) + 3'd1 : 3'(row);
  endfunction
endpackage

// File: rtl/aes_shiftrows_param_row_rotate.sv
// aes_row_rotate: rotates one NB-byte row (byte c = column c) left (forward) or right (inverse) by off
module aes_row_rotate import aes_pkg::*; #(
  parameter int NB = 4
) (
  input  logic [8*NB-1:0] row_in,
  input  logic [2:0]      off,
  input  logic            inv,
  output logic [8*NB-1:0] row_out
);
  always_comb begin
    row_out = '0;
    for (int c = 0; c < NB; c++)
      for (int j = 0; j < NB; j++)
        if (j == (inv ? c + NB - int'(off) : c + int'(off)) % NB) row_out[8*c +: 8] = row_in[8*j +: 8];
  end
endmodule

// File: rtl/aes_shiftrows_param.sv
// aes_shiftrows_param: row-serial (Inv)ShiftRows for NB=4/6/8 with start/finish handshake.
// Define AES_SHIFTROWS_ADDKEY_EN to fold AddRoundKey into the last SHIFT cycle.
module aes_shiftrows_param import aes_pkg::*; #(
  parameter int NB = 4,
  parameter int W  = 32 * NB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         inv,
  input  logic [W-1:0] in,
  input  logic [W-1:0] key,
  output logic         finish,
  output logic         busy,
  output logic [W-1:0] result
);
  aes_sr_state_e state, state_n;
  logic [1:0] cnt, cnt_n;
  logic inv_q, inv_n;
  logic [W-1:0] st, st_n, shifted, shifted_k;
  logic [8*NB-1:0] rows [4];
  logic [8*NB-1:0] rot;
  if (!nb_legal(NB)) begin : g_bad_nb
    $error("aes_shiftrows_param: NB must be 4, 6 or 8");
  end
  // Only the row selected by cnt is replaced by the rotator output; the rest pass through
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      assign rows[r][8*c +: 8] = st[W-1-8*(4*c+r) -: 8];
      assign shifted[W-1-8*(4*c+r) -: 8] = cnt == 2'(r) ? rot[8*c +: 8] : rows[r][8*c +: 8];
    end
  end
  aes_row_rotate #(.NB(NB)) u_rot (
    .row_in (rows[cnt]),
    .off    (shift_offset(NB, cnt)),
    .inv    (inv_q),
    .row_out(rot)
  );
`ifdef AES_SHIFTROWS_ADDKEY_EN
  assign shifted_k = cnt == 2'd3 ? shifted ^ key : shifted;
`else
  logic unused_key;
  assign unused_key = |key;
  assign shifted_k = shifted;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    inv_n = inv_q;
    st_n = st;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_SHIFT;
        cnt_n = 2'd1;
        inv_n = inv;
        st_n = in;
      end
      S_SHIFT: begin
        state_n = !start ? S_IDLE : cnt == 2'd3 ? S_DONE : S_SHIFT;
        cnt_n = cnt + 2'd1;
        st_n = shifted_k;
      end
      S_DONE: state_n = start ? S_DONE : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      inv_q <= 1'b0;
      st <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      inv_q <= inv_n;
      st <= st_n;
    end
  assign result = st;
  assign finish = state == S_DONE;
  assign busy = state == S_SHIFT;
endmodule

// File: tb/tb_aes_shiftrows_param.sv
// tb_aes_shiftrows_param: randomized check of NB=4 and NB=8 instances against a byte-level ShiftRows model
module tb_aes_shiftrows_param;
`ifdef AES_SHIFTROWS_ADDKEY_EN
  localparam bit ADDKEY = 1'b1;
`else
  localparam bit ADDKEY = 1'b0;
`endif
  localparam logic [127:0] FIPS_IN  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] FIPS_FWD = 128'h6b407e2a2e3d17e2e993be9673c19f11;
  localparam logic [127:0] INV_IN   = 128'hae036f511eb78e579eaf8a9c452dacac;
  localparam logic [127:0] INV_OUT  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic clk = 1'b0, rst = 1'b0;
  logic start4 = 1'b0, inv4 = 1'b0, f4, b4;
  logic [127:0] in4 = '0, key4 = '0, r4;
  logic start8 = 1'b0, inv8 = 1'b0, f8, b8;
  logic [255:0] in8 = '0, key8 = '0, r8;
  logic [255:0] exp4 = '0, exp8 = '0, got, y, d8;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  aes_shiftrows_param #(.NB(4)) dut4 (.clk(clk), .rst(rst), .start(start4), .inv(inv4), .in(in4),
    .key(key4), .finish(f4), .busy(b4), .result(r4));
  aes_shiftrows_param #(.NB(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .inv(inv8), .in(in8),
    .key(key8), .finish(f8), .busy(b8), .result(r8));

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // State is right-aligned in 32*nb bits; byte (r,c) sits 8*(4c+r) bits below the top
  function automatic logic [255:0] model(input int nb, input logic [255:0] d, input logic iv, input logic [255:0] k);
    int off[4];
    int src;
    logic [255:0] o;
    o = '0;
    off[0] = 0; off[1] = 1; off[2] = nb == 8 ? 3 : 2; off[3] = nb == 8 ? 4 : 3;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++) begin
        src = iv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
        o[32*nb-1-8*(4*c+r) -: 8] = d[32*nb-1-8*(4*src+r) -: 8];
      end
    if (ADDKEY) o = o ^ k;
    return o;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  always @(negedge clk) begin
    if (f4) chk("res4", {128'h0, r4}, exp4);
    if (f8) chk("res8", r8, exp8);
  end

  task automatic op(input bit w8, input logic [255:0] d, input logic iv, input logic [255:0] k,
                    input int hold, output logic [255:0] res);
    int n;
    res = '0;
    if (w8) begin in8 = d; inv8 = iv; key8 = k; exp8 = model(8, d, iv, k); start8 = 1'b1; end
    else begin in4 = d[127:0]; inv4 = iv; key4 = k[127:0]; exp4 = model(4, d, iv, k); start4 = 1'b1; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (w8) begin in8 = rnd256(); inv8 = ~iv; end
        else begin in4 = rnd256()[127:0]; inv4 = ~iv; end
      end
    end while (!(w8 ? f8 : f4) && n < 20);
    chk(w8 ? "lat8" : "lat4", 256'(n - 1), 256'(3));
    res = w8 ? r8 : {128'h0, r4};
    repeat (hold) @(negedge clk);
    if (w8) start8 = 1'b0; else start4 = 1'b0;
    @(negedge clk);
    chk(w8 ? "fall8" : "fall4", {255'h0, w8 ? f8 : f4}, 256'h0);
  endtask

  initial begin
    #1;
    chk("rst_f4", {255'h0, f4}, 256'h0);
    chk("rst_b4", {255'h0, b4}, 256'h0);
    chk("rst_r4", {128'h0, r4}, 256'h0);
    chk("rst_f8", {255'h0, f8}, 256'h0);
    chk("rst_r8", r8, 256'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("pin_fwd", model(4, {128'h0, FIPS_IN}, 1'b0, '0), {128'h0, FIPS_FWD});
    chk("pin_inv", model(4, {128'h0, INV_IN}, 1'b1, '0), {128'h0, INV_OUT});
    for (int i = 0; i < 32; i++) d8[255-8*i -: 8] = 8'(i);
    got = model(8, d8, 1'b0, '0);
    chk("pin_nb8", {224'h0, got[255:224]}, {224'h0, 32'h00050e13});

    op(1'b0, {128'h0, FIPS_IN}, 1'b0, '0, 0, got);
    chk("fips_fwd", got, {128'h0, FIPS_FWD});
    op(1'b0, {128'h0, INV_IN}, 1'b1, '0, 0, got);
    chk("fips_inv", got, {128'h0, INV_OUT});
    y = {128'h0, rnd256()[127:0]};
    op(1'b0, y, 1'b0, '0, 1, got);
    op(1'b0, got, 1'b1, '0, 0, got);
    chk("roundtrip", got, y);
    op(1'b1, d8, 1'b0, '0, 0, got);
    chk("nb8_col0", {224'h0, got[255:224]}, {224'h0, 32'h00050e13});
    op(1'b0, {128'h0, FIPS_IN}, 1'b0, {128'h0, FIPS_KEY}, 0, got);
    chk("key_col0", {224'h0, got[127:96]}, {224'h0, ADDKEY ? 32'h403e6b3c : 32'h6b407e2a});
    chk("key_full", got, {128'h0, ADDKEY ? FIPS_FWD ^ FIPS_KEY : FIPS_FWD});
    op(1'b0, {128'h0, rnd256()[127:0]}, 1'b1, rnd256(), 10, got);

    // abort: start sampled low on the second SHIFT edge
    in4 = rnd256()[127:0]; inv4 = 1'b0; start4 = 1'b1;
    repeat (2) @(negedge clk);
    start4 = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_f4", {255'h0, f4}, 256'h0);
    end
    chk("abort_b4", {255'h0, b4}, 256'h0);

    for (int i = 0; i < 12; i++)
      op(1'b0, {128'h0, rnd256()[127:0]}, 1'($urandom), rnd256(), $urandom_range(0, 3), got);
    for (int i = 0; i < 8; i++)
      op(1'b1, rnd256(), 1'($urandom), rnd256(), $urandom_range(0, 3), got);

    // asynchronous reset while in DONE
    in4 = FIPS_IN; inv4 = 1'b0; key4 = '0; exp4 = model(4, {128'h0, FIPS_IN}, 1'b0, '0); start4 = 1'b1;
    for (int n = 0; n < 20 && !f4; n++) @(negedge clk);
    chk("pre_rst_f4", {255'h0, f4}, 256'h1);
    #2 rst = 1'b0;
    #1;
    chk("arst_f4", {255'h0, f4}, 256'h0);
    chk("arst_r4", {128'h0, r4}, 256'h0);
    chk("arst_b4", {255'h0, b4}, 256'h0);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    op(1'b0, {128'h0, INV_IN}, 1'b1, '0, 0, got);
    chk("post_rst", got, {128'h0, INV_OUT});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
